// File: rtl/diy_mole_recorder_pkg.sv
// Shared types for the DIY mole recorder: FSM encoding, entry layout and widths.
// Optional step de-duplication is enabled with the DIY_REC_DEDUP_EN macro.
package diy_mole_recorder_pkg;

    localparam int MUSIC_ADDR_W = 23;
    localparam int LOC_W        = 3;
    localparam int ENTRY_W      = MUSIC_ADDR_W + LOC_W;

    typedef enum logic [1:0] {
        REC_IDLE      = 2'd0,
        REC_RECORDING = 2'd1,
        REC_DONE      = 2'd2
    } rec_state_e;

    // Address in the upper bits so a flat 26-bit word reads as {address, location}.
    typedef struct packed {
        logic [MUSIC_ADDR_W-1:0] addr;
        logic [LOC_W-1:0]        loc;
    } mole_entry_t;

    function automatic mole_entry_t make_entry(
        input logic [MUSIC_ADDR_W-1:0] addr,
        input logic [LOC_W-1:0]        loc
    );
        mole_entry_t e;
        e.addr = addr;
        e.loc  = loc;
        return e;
    endfunction

endpackage

// File: rtl/diy_mole_recorder_entry_ram.sv
// Simple dual-port entry store: one write port, one registered read-before-write read port.
// The read register is cleared by reset; the array itself is never cleared.
module mole_entry_ram
    import diy_mole_recorder_pkg::*;
#(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  mole_entry_t       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output mole_entry_t       rdata
);

    mole_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking read of the array gives old data on a same-address write.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/diy_mole_recorder.sv
// DIY mole recorder: records (music_address, location) steps and serves them for playback.
// Define DIY_REC_DEDUP_EN to reject steps closer than MIN_GAP to the previous accepted one.
module diy_mole_recorder
    import diy_mole_recorder_pkg::*;
#(
    parameter int                      DEPTH      = 128,
    parameter int                      INDEX_BITS = 8,
    parameter logic [MUSIC_ADDR_W-1:0] MIN_GAP    = 23'h2000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    diy_mode,
    input  logic                    record_start,
    input  logic                    record_stop,
    input  logic                    step_valid,
    input  logic [LOC_W-1:0]        step_location,
    input  logic [MUSIC_ADDR_W-1:0] music_address,
    input  logic [INDEX_BITS-1:0]   lookup_index,
    output logic [MUSIC_ADDR_W-1:0] index_address,
    output logic [LOC_W-1:0]        index_location,
    output logic [INDEX_BITS-1:0]   total_moles,
    output logic                    ready_to_use,
    output logic                    full,
    output logic                    recording
);

    localparam int                    ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [INDEX_BITS-1:0] DEPTH_CNT = INDEX_BITS'(DEPTH);

`ifdef DIY_REC_DEDUP_EN
    localparam bit DEDUP_EN = 1'b1;
`else
    localparam bit DEDUP_EN = 1'b0;
`endif

    rec_state_e              state, state_next;
    logic [INDEX_BITS-1:0]   count, count_next, count_inc;
    logic [MUSIC_ADDR_W-1:0] last_addr, last_addr_next, addr_delta;
    logic                    count_full, in_order, gap_ok, accept;
    logic [ADDR_W-1:0]       rd_addr;
    mole_entry_t             rd_entry;

    assign count_inc  = count + 1'b1;
    assign count_full = (count == DEPTH_CNT);
    assign addr_delta = music_address - last_addr;

    // A decreasing address means the music restarted; such steps are silently dropped.
    assign in_order = (music_address >= last_addr);
    assign gap_ok   = !DEDUP_EN || (count == '0) || (addr_delta >= MIN_GAP);
    assign accept   = diy_mode && (state == REC_RECORDING) && step_valid &&
                      !count_full && in_order && gap_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= REC_IDLE;
            count     <= '0;
            last_addr <= '0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            last_addr <= last_addr_next;
        end
    end

    always_comb begin
        state_next     = state;
        count_next     = count;
        last_addr_next = last_addr;
        if (!diy_mode) begin
            state_next = REC_IDLE;
            count_next = '0;
        end else begin
            case (state)
                REC_IDLE: begin
                    if (record_start) begin
                        state_next     = REC_RECORDING;
                        count_next     = '0;
                        last_addr_next = '0;
                    end
                end
                REC_RECORDING: begin
                    if (accept) begin
                        count_next     = count_inc;
                        last_addr_next = music_address;
                    end
                    // A step arriving with record_stop is counted before the stop decision.
                    if (accept && (count_inc == DEPTH_CNT)) begin
                        state_next = REC_DONE;
                    end else if (record_stop) begin
                        state_next = (count_next != '0) ? REC_DONE : REC_IDLE;
                    end
                end
                REC_DONE: begin
                    if (record_start) begin
                        state_next     = REC_RECORDING;
                        count_next     = '0;
                        last_addr_next = '0;
                    end
                end
                default: begin
                    state_next = REC_IDLE;
                    count_next = '0;
                end
            endcase
        end
    end

    // Out-of-range lookups fall back to entry 0.
    assign rd_addr = (lookup_index < count) ? lookup_index[ADDR_W-1:0] : '0;

    mole_entry_ram #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_entry_ram (
        .clk  (clk),
        .reset(reset),
        .we   (accept),
        .waddr(count[ADDR_W-1:0]),
        .wdata(make_entry(music_address, step_location)),
        .raddr(rd_addr),
        .rdata(rd_entry)
    );

    assign index_address  = rd_entry.addr;
    assign index_location = rd_entry.loc;
    assign total_moles    = count;
    assign full           = count_full;
    assign ready_to_use   = (state == REC_DONE);
    assign recording      = (state == REC_RECORDING);

endmodule

// File: tb/tb_diy_mole_recorder.sv
// Bench for diy_mole_recorder: directed scenarios then random traffic against a queue-based model.
// Model honours DIY_REC_DEDUP_EN the same way the build does.
module tb_diy_mole_recorder;
  import diy_mole_recorder_pkg::*;

  localparam int TB_DEPTH = 4;
  localparam logic [22:0] TB_GAP = 23'h2000;
`ifdef DIY_REC_DEDUP_EN
  localparam bit TB_DEDUP = 1'b1;
`else
  localparam bit TB_DEDUP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, diy_mode, record_start, record_stop, step_valid;
  logic [2:0] step_location;
  logic [22:0] music_address;
  logic [7:0] lookup_index;
  logic [22:0] index_address;
  logic [2:0] index_location;
  logic [7:0] total_moles;
  logic ready_to_use, full, recording;

  int n_vec = 0;
  int n_err = 0;

  // model: recorded entries in press order, plus the persistent store image
  logic [25:0] exp_q[$];
  logic [25:0] m_mem[TB_DEPTH];
  bit m_mem_ok[TB_DEPTH];
  bit m_rec = 0;
  bit m_done = 0;
  logic [22:0] m_last = '0;
  logic [25:0] exp_rd;
  bit exp_rd_ok;

  always #5 clk = ~clk;

  diy_mole_recorder #(.DEPTH(TB_DEPTH), .INDEX_BITS(8), .MIN_GAP(TB_GAP)) dut (
    .clk(clk), .reset(reset), .diy_mode(diy_mode), .record_start(record_start),
    .record_stop(record_stop), .step_valid(step_valid), .step_location(step_location),
    .music_address(music_address), .lookup_index(lookup_index),
    .index_address(index_address), .index_location(index_location),
    .total_moles(total_moles), .ready_to_use(ready_to_use), .full(full),
    .recording(recording)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit rst, input bit diy, input bit start, input bit stop,
                              input bit step, input logic [2:0] loc, input logic [22:0] addr,
                              input logic [7:0] look);
    int n;
    int idx;
    logic [22:0] diff;
    n = exp_q.size();
    idx = (int'(look) < n) ? int'(look) : 0;
    exp_rd_ok = rst ? 1'b1 : m_mem_ok[idx];
    exp_rd = rst ? 26'h0 : m_mem[idx];
    if (rst) begin
      m_rec = 0; m_done = 0; m_last = '0;
      exp_q.delete();
    end else if (!diy) begin
      m_rec = 0; m_done = 0;
      exp_q.delete();
    end else if (m_rec) begin
      diff = addr - m_last;
      if (step && n < TB_DEPTH && addr >= m_last &&
          (!TB_DEDUP || n == 0 || diff >= TB_GAP)) begin
        m_mem[n] = {addr, loc};
        m_mem_ok[n] = 1'b1;
        exp_q.push_back({addr, loc});
        m_last = addr;
      end
      if (exp_q.size() == TB_DEPTH) begin
        m_rec = 0; m_done = 1;
      end else if (stop) begin
        m_rec = 0;
        m_done = (exp_q.size() > 0);
      end
    end else if (start) begin
      m_rec = 1; m_done = 0; m_last = '0;
      exp_q.delete();
    end
  endtask

  // one clock: apply inputs, advance the model, sample outputs 1 time unit after the edge
  task automatic drive(input bit rst, input bit diy, input bit start, input bit stop,
                       input bit step, input logic [2:0] loc, input logic [22:0] addr,
                       input logic [7:0] look);
    reset = rst; diy_mode = diy; record_start = start; record_stop = stop;
    step_valid = step; step_location = loc; music_address = addr; lookup_index = look;
    model_update(rst, diy, start, stop, step, loc, addr, look);
    @(posedge clk);
    #1;
    chk("total_moles", 32'(total_moles), 32'(exp_q.size()));
    chk("ready_to_use", 32'(ready_to_use), 32'(m_done));
    chk("full", 32'(full), 32'(exp_q.size() == TB_DEPTH));
    chk("recording", 32'(recording), 32'(m_rec));
    if (exp_rd_ok) begin
      chk("index_address", 32'(index_address), 32'(exp_rd[25:3]));
      chk("index_location", 32'(index_location), 32'(exp_rd[2:0]));
    end
  endtask

  task automatic idle_cyc(input logic [7:0] look);
    drive(0, 1, 0, 0, 0, 3'd0, 23'h0, look);
  endtask

  task automatic start_cyc();
    drive(0, 1, 1, 0, 0, 3'd0, 23'h0, 8'd0);
  endtask

  task automatic step_cyc(input logic [22:0] addr, input logic [2:0] loc);
    drive(0, 1, 0, 0, 1, loc, addr, 8'd0);
  endtask

  task automatic stop_cyc();
    drive(0, 1, 0, 1, 0, 3'd0, 23'h0, 8'd0);
  endtask

  initial begin
    logic [22:0] raddr;
    for (int i = 0; i < TB_DEPTH; i++) m_mem_ok[i] = 1'b0;

    drive(1, 0, 0, 0, 0, 3'd0, 23'h0, 8'd0);
    drive(1, 0, 0, 0, 0, 3'd0, 23'h0, 8'd0);
    chk("reset_total", 32'(total_moles), 32'd0);
    chk("reset_rd_addr", 32'(index_address), 32'd0);

    // basic record
    idle_cyc(8'd0);
    start_cyc();
    step_cyc(23'h1000, 3'd3);
    step_cyc(23'h5000, 3'd7);
    stop_cyc();
    chk("basic_total", 32'(total_moles), 32'd2);
    chk("basic_ready", 32'(ready_to_use), 32'd1);
    idle_cyc(8'd1);
    chk("basic_rd_addr", 32'(index_address), 32'h5000);
    chk("basic_rd_loc", 32'(index_location), 32'd7);
    idle_cyc(8'd9);
    chk("oob_rd_addr", 32'(index_address), 32'h1000);

    // empty stop
    start_cyc();
    stop_cyc();
    chk("empty_recording", 32'(recording), 32'd0);
    chk("empty_ready", 32'(ready_to_use), 32'd0);
    chk("empty_total", 32'(total_moles), 32'd0);

    // full: fifth step lands in DONE and is ignored
    start_cyc();
    for (int i = 0; i < 5; i++) begin
      step_cyc(23'h10000 + 23'(i) * 23'h4000, 3'(i));
      if (i == 3) begin
        chk("full_flag", 32'(full), 32'd1);
        chk("full_done", 32'(ready_to_use), 32'd1);
      end
    end
    chk("full_total", 32'(total_moles), 32'd4);

    // abort by leaving DIY mode
    start_cyc();
    for (int i = 0; i < 3; i++) step_cyc(23'h2000 + 23'(i) * 23'h3000, 3'd1);
    drive(0, 0, 0, 0, 0, 3'd0, 23'h0, 8'd0);
    chk("abort_total", 32'(total_moles), 32'd0);
    chk("abort_recording", 32'(recording), 32'd0);

    // reset while DONE
    start_cyc();
    step_cyc(23'h4000, 3'd2);
    stop_cyc();
    drive(1, 1, 0, 0, 0, 3'd0, 23'h0, 8'd0);
    chk("rst_done_ready", 32'(ready_to_use), 32'd0);
    chk("rst_done_total", 32'(total_moles), 32'd0);

    // step and stop in the same cycle
    start_cyc();
    step_cyc(23'h1000, 3'd1);
    drive(0, 1, 0, 1, 1, 3'd5, 23'h6000, 8'd0);
    chk("simul_total", 32'(total_moles), 32'd2);
    chk("simul_ready", 32'(ready_to_use), 32'd1);
    idle_cyc(8'd1);
    chk("simul_rd_addr", 32'(index_address), 32'h6000);
    chk("simul_rd_loc", 32'(index_location), 32'd5);

    // minimum-gap filter
    start_cyc();
    step_cyc(23'h1000, 3'd0);
    step_cyc(23'h2500, 3'd1);
    step_cyc(23'h3000, 3'd2);
    stop_cyc();
    chk("dedup_total", 32'(total_moles), TB_DEDUP ? 32'd2 : 32'd3);

    // music restart drops the out-of-order step
    start_cyc();
    step_cyc(23'h8000, 3'd4);
    step_cyc(23'h4000, 3'd5);
    step_cyc(23'hB000, 3'd6);
    stop_cyc();
    chk("order_total", 32'(total_moles), 32'd2);

    // random traffic
    raddr = '0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 9) == 0) raddr = 23'($urandom_range(0, 32'h1000));
      else raddr = raddr + 23'($urandom_range(0, 32'h3000));
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 49) != 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0,
            $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), raddr,
            8'($urandom_range(0, 6)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
